// File: rtl/l3_svc_pkg.sv
// Shared types and default widths for the L3 FIFO service engine.
// Optional perf counter in the top is enabled with L3_SVC_PERF_CNT_EN.
package l3_svc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARB       = 2'd1,
        REQ       = 2'd2,
        WAIT_DATA = 2'd3
    } state_e;

    localparam int L3_NUM_CH = 32;
    localparam int L3_DATA_W = 32;
    localparam int L3_ADDR_W = 32;
    localparam int L3_LEN_W  = 7;

endpackage

// File: rtl/l3_fifo_service_engine_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr.
module rr_arbiter #(
    parameter int N  = 32,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    logic [N-1:0] rot;
    int           off;
    int           sum;

    // Rotate so that bit 0 corresponds to the pointer position.
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        gnt_valid = 1'b0;
        off       = 0;
        sum       = 0;
        gnt_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_valid = 1'b1;
                off       = i;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= N) sum = sum - N;
        gnt_idx = PW'(sum);
    end

endmodule

// File: rtl/l3_fifo_service_engine.sv
// Refill responder for the L2 need/done FIFO protocol: RR-arbitrates need_i, one GLB beat per grant.
// Define L3_SVC_PERF_CNT_EN to add the perf_wait_cycles_o stall counter.
module l3_fifo_service_engine
    import l3_svc_pkg::*;
#(
    parameter int NUM_CH = L3_NUM_CH,
    parameter int DATA_W = L3_DATA_W,
    parameter int ADDR_W = L3_ADDR_W,
    parameter int LEN_W  = L3_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] need_i,
    output logic [NUM_CH-1:0] done_o,
    input  logic [LEN_W-1:0]  xfer_len_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] ch_stride_i,
    input  logic              row_clear_i,
    input  logic [NUM_CH-1:0] fifo_full_i,
    output logic [NUM_CH-1:0] fifo_push_o,
    output logic [DATA_W-1:0] fifo_wdata_o,
    output logic              glb_req_o,
    output logic [ADDR_W-1:0] glb_addr_o,
    input  logic              glb_gnt_i,
    input  logic              glb_rvalid_i,
    input  logic [DATA_W-1:0] glb_rdata_i
`ifdef L3_SVC_PERF_CNT_EN
    ,
    output logic [31:0]       perf_wait_cycles_o
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                         state, state_nxt;
    logic [CH_W-1:0]                ch, rr_ptr;
    logic [NUM_CH-1:0][LEN_W-1:0]   cnt;
    logic                           clear_pend;
    logic [NUM_CH-1:0]              eligible;
    logic                           gnt_valid;
    logic [CH_W-1:0]                gnt_idx;
    logic                           push;
    logic                           clear_now;
    logic [LEN_W-1:0]               cnt_inc;

    assign eligible = need_i & ~done_o & ~fifo_full_i;

    rr_arbiter #(.N(NUM_CH), .PW(CH_W)) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign push    = (state == WAIT_DATA) && glb_rvalid_i;
    assign cnt_inc = cnt[ch] + 1'b1;

    // A clear raised mid-transaction waits for the in-flight beat's push cycle.
    assign clear_now = push ? (clear_pend | row_clear_i)
                            : (row_clear_i && (state == IDLE || state == ARB));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (|need_i) state_nxt = ARB;
            ARB: begin
                if (row_clear_i || xfer_len_i == '0 || !gnt_valid) state_nxt = IDLE;
                else                                                state_nxt = REQ;
            end
            REQ:       if (glb_gnt_i) state_nxt = WAIT_DATA;
            WAIT_DATA: if (glb_rvalid_i) state_nxt = (clear_pend || row_clear_i) ? IDLE : ARB;
            default:   state_nxt = IDLE;
        endcase
    end

    assign glb_req_o    = (state == REQ);
    assign glb_addr_o   = (state == REQ)
                        ? base_addr_i + ADDR_W'(ch) * ch_stride_i + ADDR_W'(cnt[ch])
                        : '0;
    assign fifo_push_o  = push ? ({{(NUM_CH-1){1'b0}}, 1'b1} << ch) : '0;
    assign fifo_wdata_o = push ? glb_rdata_i : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            rr_ptr     <= '0;
            cnt        <= '0;
            done_o     <= '0;
            clear_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear_now) begin
                cnt        <= '0;
                done_o     <= '0;
                clear_pend <= 1'b0;
            end else begin
                if (row_clear_i && (state == REQ || state == WAIT_DATA)) clear_pend <= 1'b1;
                if (state == ARB && xfer_len_i == '0) done_o <= done_o | need_i;
                if (state == ARB && xfer_len_i != '0 && gnt_valid) begin
                    ch     <= gnt_idx;
                    rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                end
                if (push) begin
                    cnt[ch] <= cnt_inc;
                    if (cnt_inc == xfer_len_i) done_o[ch] <= 1'b1;
                end
            end
        end
    end

`ifdef L3_SVC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_wait_cycles_o <= '0;
        end else if (row_clear_i) begin
            perf_wait_cycles_o <= '0;
        end else if (((state == REQ && !glb_gnt_i) || (state == WAIT_DATA && !glb_rvalid_i))
                     && perf_wait_cycles_o != '1) begin
            perf_wait_cycles_o <= perf_wait_cycles_o + 32'd1;
        end
    end
`endif

endmodule
